core_boot_sequencer: RTL and testbench

- Front-end controller that drives a single RISC_V_Core's control inputs: reset, start, prog_address and report.
- On a boot request it performs these steps in order:
  - holds the core in reset for a programmable number of cycles;
  - presents the entry address and pulses start for one cycle;
  - counts run cycles until the core signals halt or a timeout expires;
  - pulses report for one cycle.
- Replaces hand-written reset/start sequencing in benches and top levels.

---
 rtl/core_boot_sequencer_if.sv | 35 +++
 rtl/core_boot_sequencer.sv | 144 ++++++++++++++
 tb/tb_core_boot_sequencer.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/core_boot_sequencer_if.sv
// core_boot_sequencer_if: groups the sequencer's control, status and core-drive signals.
//   boot_req, boot_address, abort, halt       requester -> sequencer
//   core_reset, core_start, prog_address,
//   report                                    sequencer -> core
//   busy, done, timeout, cycle_count          sequencer status
// Modports:
//   master  the requester/bench side; drives requests and halt.
//   slave   the sequencer side; drives the core controls and status.
interface core_boot_sequencer_if #(
  parameter int unsigned ADDRESS_BITS = 20,
  parameter int unsigned COUNT_BITS   = 32
);
  logic                    boot_req;
  logic [ADDRESS_BITS-1:0] boot_address;
  logic                    abort;
  logic                    halt;
  logic                    core_reset;
  logic                    core_start;
  logic [ADDRESS_BITS-1:0] prog_address;
  logic                    report;
  logic                    busy;
  logic                    done;
  logic                    timeout;
  logic [COUNT_BITS-1:0]   cycle_count;

  modport master (
    output boot_req, boot_address, abort, halt,
    input  core_reset, core_start, prog_address, report, busy, done, timeout, cycle_count
  );

  modport slave (
    input  boot_req, boot_address, abort, halt,
    output core_reset, core_start, prog_address, report, busy, done, timeout, cycle_count
  );
endinterface

// File: rtl/core_boot_sequencer.sv
// core_boot_sequencer: drives a RISC-V core through reset hold, start pulse, run and report.
// Ports:
//   clock  system clock, rising-edge
//   reset  asynchronous active-high reset
//   bus    core_boot_sequencer_if.slave: boot_req/boot_address/abort/halt in;
//          core_reset/core_start/prog_address/report/busy/done/timeout/cycle_count out
// All outputs are registered; control outputs are decoded from the next state so they
// line up with the state register.
module core_boot_sequencer #(
  parameter int unsigned ADDRESS_BITS = 20,
  parameter int unsigned RESET_CYCLES = 1,
  parameter int unsigned COUNT_BITS   = 32,
  parameter int unsigned MAX_CYCLES   = 100000
) (
  input logic                  clock,
  input logic                  reset,
  core_boot_sequencer_if.slave bus
);

  localparam int unsigned HoldBits = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [HoldBits-1:0]   HoldInit = HoldBits'(RESET_CYCLES - 1);
  localparam logic [COUNT_BITS-1:0] MaxCount = COUNT_BITS'(MAX_CYCLES);

  typedef enum logic [2:0] {
    StIdle,
    StHold,
    StStart,
    StRun,
    StReport,
    StDone
  } state_e;

  state_e                  state_q, state_d;
  logic [HoldBits-1:0]     hold_q, hold_d;
  logic [COUNT_BITS-1:0]   count_q, count_d, count_inc;
  logic                    timeout_q, timeout_d;
  logic [ADDRESS_BITS-1:0] addr_q, addr_d;

  logic core_reset_q, core_reset_d;
  logic core_start_q, core_start_d;
  logic report_q, report_d;
  logic busy_q, busy_d;
  logic done_q, done_d;

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    count_d   = count_q;
    timeout_d = timeout_q;
    addr_d    = addr_q;
    // Saturating increment; the RUN exit test looks at this value.
    count_inc = (count_q == '1) ? count_q : count_q + COUNT_BITS'(1);

    case (state_q)
      StIdle, StDone: begin
        if (bus.boot_req) begin
          addr_d    = bus.boot_address;
          count_d   = '0;
          timeout_d = 1'b0;
          hold_d    = HoldInit;
          state_d   = StHold;
        end
      end
      StHold: begin
        if (bus.abort) begin
          timeout_d = 1'b0;
          state_d   = StIdle;
        end else if (hold_q == '0) begin
          state_d = StStart;
        end else begin
          hold_d = hold_q - HoldBits'(1);
        end
      end
      StStart: begin
        if (bus.abort) begin
          timeout_d = 1'b0;
          state_d   = StIdle;
        end else begin
          state_d = StRun;
        end
      end
      StRun: begin
        // Abort beats halt and timeout; the partial count is kept as-is.
        if (bus.abort) begin
          timeout_d = 1'b0;
          state_d   = StIdle;
        end else begin
          count_d = count_inc;
          if (bus.halt) begin
            state_d = StReport;
          end else if ((MAX_CYCLES != 0) && (count_inc == MaxCount)) begin
            timeout_d = 1'b1;
            state_d   = StReport;
          end
        end
      end
      StReport: state_d = StDone;
      default:  state_d = StIdle;
    endcase

    core_reset_d = (state_d == StIdle) || (state_d == StHold) || (state_d == StDone);
    core_start_d = (state_d == StStart);
    report_d     = (state_d == StReport);
    busy_d       = (state_d == StHold) || (state_d == StStart) ||
                   (state_d == StRun) || (state_d == StReport);
    done_d       = (state_d == StDone);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      hold_q       <= '0;
      count_q      <= '0;
      timeout_q    <= 1'b0;
      addr_q       <= '0;
      core_reset_q <= 1'b1;
      core_start_q <= 1'b0;
      report_q     <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      count_q      <= count_d;
      timeout_q    <= timeout_d;
      addr_q       <= addr_d;
      core_reset_q <= core_reset_d;
      core_start_q <= core_start_d;
      report_q     <= report_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign bus.core_reset   = core_reset_q;
  assign bus.core_start   = core_start_q;
  assign bus.prog_address = addr_q;
  assign bus.report       = report_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.timeout      = timeout_q;
  assign bus.cycle_count  = count_q;

endmodule

// File: tb/tb_core_boot_sequencer.sv
// tb_core_boot_sequencer: three sequencer instances share one stimulus.
//   u0: RESET_CYCLES=1, MAX_CYCLES=0   u1: RESET_CYCLES=1, MAX_CYCLES=8
//   u2: RESET_CYCLES=3, MAX_CYCLES=4
module tb_core_boot_sequencer;

  logic        clock;
  logic        reset;
  logic        boot_req;
  logic [19:0] boot_address;
  logic        abort;
  logic        halt;

  core_boot_sequencer_if #(.ADDRESS_BITS(20), .COUNT_BITS(32)) if0 ();
  core_boot_sequencer_if #(.ADDRESS_BITS(20), .COUNT_BITS(32)) if1 ();
  core_boot_sequencer_if #(.ADDRESS_BITS(20), .COUNT_BITS(32)) if2 ();

  assign if0.boot_req = boot_req;
  assign if0.boot_address = boot_address;
  assign if0.abort = abort;
  assign if0.halt = halt;
  assign if1.boot_req = boot_req;
  assign if1.boot_address = boot_address;
  assign if1.abort = abort;
  assign if1.halt = halt;
  assign if2.boot_req = boot_req;
  assign if2.boot_address = boot_address;
  assign if2.abort = abort;
  assign if2.halt = halt;

  core_boot_sequencer #(.ADDRESS_BITS(20), .RESET_CYCLES(1), .COUNT_BITS(32), .MAX_CYCLES(0))
    u0 (.clock(clock), .reset(reset), .bus(if0));
  core_boot_sequencer #(.ADDRESS_BITS(20), .RESET_CYCLES(1), .COUNT_BITS(32), .MAX_CYCLES(8))
    u1 (.clock(clock), .reset(reset), .bus(if1));
  core_boot_sequencer #(.ADDRESS_BITS(20), .RESET_CYCLES(3), .COUNT_BITS(32), .MAX_CYCLES(4))
    u2 (.clock(clock), .reset(reset), .bus(if2));

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_u0(input string tag, input logic cr, input logic cs, input logic rep,
                          input logic bsy, input logic dn, input logic to,
                          input logic [31:0] cnt, input logic [19:0] pa);
    check($sformatf("%s.core_reset", tag), 64'(if0.core_reset), 64'(cr));
    check($sformatf("%s.core_start", tag), 64'(if0.core_start), 64'(cs));
    check($sformatf("%s.report", tag), 64'(if0.report), 64'(rep));
    check($sformatf("%s.busy", tag), 64'(if0.busy), 64'(bsy));
    check($sformatf("%s.done", tag), 64'(if0.done), 64'(dn));
    check($sformatf("%s.timeout", tag), 64'(if0.timeout), 64'(to));
    check($sformatf("%s.cycle_count", tag), 64'(if0.cycle_count), 64'(cnt));
    check($sformatf("%s.prog_address", tag), 64'(if0.prog_address), 64'(pa));
  endtask

  // Sample #1 after the active edge; inputs are then driven for the next edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    boot_req = 1'b0;
    boot_address = '0;
    abort = 1'b0;
    halt = 1'b0;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  typedef struct {
    logic        boot_req;
    logic [19:0] addr;
    logic        abort;
    logic        halt;
    logic        cr, cs, rep, bsy, dn, to;
    logic [31:0] cnt;
    logic [19:0] pa;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int  n;
    bit  seen;

    // Basic boot on u0: HOLD 1 cycle, START, RUN, halt on the 5th RUN edge.
    vecs[0] = '{1'b1, 20'h00100, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 20'h00100};
    vecs[1] = '{1'b0, 20'h00000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 20'h00100};
    vecs[2] = '{1'b0, 20'h00000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 20'h00100};
    vecs[3] = '{1'b0, 20'h00000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd1, 20'h00100};
    vecs[4] = '{1'b0, 20'h00000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd2, 20'h00100};
    vecs[5] = '{1'b0, 20'h00000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd3, 20'h00100};
    vecs[6] = '{1'b0, 20'h00000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd4, 20'h00100};
    vecs[7] = '{1'b0, 20'h00000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'd5, 20'h00100};
    vecs[8] = '{1'b0, 20'h00000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd5, 20'h00100};
    // Abort and halt are both ignored in DONE.
    vecs[9] = '{1'b0, 20'h00000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd5, 20'h00100};

    // Reset applied before any clock edge.
    boot_req = 1'b0;
    boot_address = '0;
    abort = 1'b0;
    halt = 1'b0;
    reset = 1'b1;
    #2;
    check_u0("reset0", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 20'h0);
    step();
    step();
    reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      boot_req = vecs[i].boot_req;
      boot_address = vecs[i].addr;
      abort = vecs[i].abort;
      halt = vecs[i].halt;
      step();
      check_u0($sformatf("basic[%0d]", i), vecs[i].cr, vecs[i].cs, vecs[i].rep, vecs[i].bsy,
               vecs[i].dn, vecs[i].to, vecs[i].cnt, vecs[i].pa);
    end
    boot_req = 1'b0;
    abort = 1'b0;
    halt = 1'b0;

    // Asynchronous reset mid-RUN, asserted between edges.
    do_reset();
    boot_req = 1'b1;
    boot_address = 20'h0abcd;
    step();
    boot_req = 1'b0;
    step();
    step();
    step();
    #3 reset = 1'b1;
    #1;
    check_u0("async_rst", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 20'h0);
    step();
    reset = 1'b0;

    // Timeout on u1 (MAX_CYCLES=8); u0 has no timeout and keeps running.
    do_reset();
    boot_req = 1'b1;
    boot_address = 20'h00200;
    step();
    boot_req = 1'b0;
    seen = 1'b0;
    for (n = 2; n <= 40; n++) begin
      step();
      if (if1.report) begin
        seen = 1'b1;
        break;
      end
    end
    check("to.report_seen", 64'(seen), 64'd1);
    check("to.report_edge", 64'(n), 64'd11);
    check("to.count_at_report", 64'(if1.cycle_count), 64'd8);
    step();
    check("to.done", 64'(if1.done), 64'd1);
    check("to.report_one_cycle", 64'(if1.report), 64'd0);
    check("to.timeout", 64'(if1.timeout), 64'd1);
    check("to.count", 64'(if1.cycle_count), 64'd8);
    check("to.busy", 64'(if1.busy), 64'd0);
    check("to.core_reset", 64'(if1.core_reset), 64'd1);
    check("to.u0_busy", 64'(if0.busy), 64'd1);
    check("to.u0_count", 64'(if0.cycle_count), 64'd9);
    boot_req = 1'b1;
    boot_address = 20'h00040;
    step();
    boot_req = 1'b0;
    check("reboot.done", 64'(if1.done), 64'd0);
    check("reboot.busy", 64'(if1.busy), 64'd1);
    check("reboot.core_reset", 64'(if1.core_reset), 64'd1);
    check("reboot.count", 64'(if1.cycle_count), 64'd0);
    check("reboot.timeout", 64'(if1.timeout), 64'd0);
    check("reboot.prog_address", 64'(if1.prog_address), 64'h40);
    check("reboot.u0_ignored", 64'(if0.prog_address), 64'h200);

    // u2: 3-cycle hold, ignored boot_req in RUN, halt on the timeout edge.
    do_reset();
    boot_req = 1'b1;
    boot_address = 20'h00300;
    step();
    boot_req = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("hold3[%0d].core_reset", k), 64'(if2.core_reset), 64'd1);
      check($sformatf("hold3[%0d].core_start", k), 64'(if2.core_start), 64'd0);
      if (k < 2) step();
    end
    step();
    check("hold3.start", 64'(if2.core_start), 64'd1);
    check("hold3.start_reset", 64'(if2.core_reset), 64'd0);
    check("hold3.start_addr", 64'(if2.prog_address), 64'h300);
    step();
    check("hold3.start_one_cycle", 64'(if2.core_start), 64'd0);
    boot_req = 1'b1;
    boot_address = 20'h003ff;
    step();
    step();
    boot_req = 1'b0;
    check("run_breq.addr", 64'(if2.prog_address), 64'h300);
    check("run_breq.count", 64'(if2.cycle_count), 64'd2);
    check("run_breq.busy", 64'(if2.busy), 64'd1);
    step();
    halt = 1'b1;
    step();
    halt = 1'b0;
    check("sim.report", 64'(if2.report), 64'd1);
    check("sim.count", 64'(if2.cycle_count), 64'd4);
    check("sim.timeout", 64'(if2.timeout), 64'd0);
    step();
    check("sim.done", 64'(if2.done), 64'd1);
    check("sim.done_timeout", 64'(if2.timeout), 64'd0);
    check("sim.done_count", 64'(if2.cycle_count), 64'd4);

    // Abort on the same edge as halt (u0).
    do_reset();
    boot_req = 1'b1;
    boot_address = 20'h00111;
    step();
    boot_req = 1'b0;
    step();
    step();
    step();
    abort = 1'b1;
    halt = 1'b1;
    step();
    abort = 1'b0;
    halt = 1'b0;
    check_u0("abort_halt", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd1, 20'h00111);
    step();
    check("abort_halt.no_report", 64'(if0.report), 64'd0);
    check("abort_halt.idle", 64'(if0.busy), 64'd0);

    // Abort after 2 RUN edges, then a clean reboot (u0).
    do_reset();
    boot_req = 1'b1;
    boot_address = 20'h00500;
    step();
    boot_req = 1'b0;
    step();
    step();
    step();
    step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    check_u0("abort_run", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd2, 20'h00500);
    boot_req = 1'b1;
    boot_address = 20'h00600;
    step();
    boot_req = 1'b0;
    check_u0("after_abort.hold", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 20'h00600);
    step();
    step();
    step();
    step();
    halt = 1'b1;
    step();
    halt = 1'b0;
    check_u0("after_abort.report", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'd3, 20'h00600);
    step();
    check_u0("after_abort.done", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd3, 20'h00600);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1);
  end

endmodule
